// File: rtl/kong_keys_ctrl.sv
// PS/2 make/break events to Kong move requests: held direction levels plus a one-frame jump pulse.
// Latency: 1 cycle from event to held level; jump shows in the frame after the press. No backpressure.
module kong_keys_ctrl #(
    parameter logic [8:0] KEY_LEFT     = 9'h16B,
    parameter logic [8:0] KEY_RIGHT    = 9'h174,
    parameter logic [8:0] KEY_UP       = 9'h175,
    parameter logic [8:0] KEY_DOWN     = 9'h172,
    parameter logic [8:0] KEY_JUMP     = 9'h029,
    parameter logic [9:0] HOLD_TIMEOUT = 10'd600
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    input  logic       pause,
    output logic       ask_move_left,
    output logic       ask_move_right,
    output logic       ask_move_up,
    output logic       ask_move_down,
    output logic       ask_move_jump
);

    typedef enum logic {J_IDLE, J_HELD} jump_state_e;

    jump_state_e jump_state_q;
    logic        jump_pending_q;
    logic        jump_active_q;
    logic [3:0]  held_q, held_d;
    logic [9:0]  cnt_q [5];
    logic [9:0]  cnt_d [5];

    logic [4:0]  match;
    logic [4:0]  press;
    logic [4:0]  rel;
    logic [4:0]  held_all;
    logic [4:0]  timeout;
    logic        jump_set;

    // Index 0..3 are left/right/up/down, index 4 is jump.
    assign match    = {keyCode == KEY_JUMP, keyCode == KEY_DOWN, keyCode == KEY_UP,
                       keyCode == KEY_RIGHT, keyCode == KEY_LEFT};
    assign rel      = {5{brakee}} & match;
    assign press    = {5{make & ~brakee}} & match;
    assign held_all = {jump_state_q == J_HELD, held_q};
    assign jump_set = press[4] & (jump_state_q == J_IDLE);

    always_comb begin
        timeout = '0;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
            // An event on the key in the timeout frame counts as activity and wins.
            timeout[i] = startOfFrame & held_all[i] & ~(press[i] | rel[i])
                       & (cnt_q[i] >= HOLD_TIMEOUT - 10'd1);
            if (press[i] | rel[i] | timeout[i]) begin
                cnt_d[i] = '0;
            end else if (startOfFrame && held_all[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 10'd1;
            end
        end
    end

    always_comb begin
        held_d = held_q;
        for (int i = 0; i < 4; i++) begin
            if (rel[i]) begin
                held_d[i] = 1'b0;
            end else if (press[i]) begin
                held_d[i] = 1'b1;
            end else if (timeout[i]) begin
                held_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            held_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            held_q <= held_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            jump_state_q   <= J_IDLE;
            jump_pending_q <= 1'b0;
            jump_active_q  <= 1'b0;
        end else begin
            case (jump_state_q)
                J_IDLE: if (press[4]) jump_state_q <= J_HELD;
                J_HELD: if (rel[4] | timeout[4]) jump_state_q <= J_IDLE;
                default: jump_state_q <= J_IDLE;
            endcase
            // A press landing on the frame boundary is kept for the next frame.
            if (startOfFrame) begin
                jump_active_q  <= jump_pending_q & ~pause;
                jump_pending_q <= jump_set;
            end else if (jump_set) begin
                jump_pending_q <= 1'b1;
            end
        end
    end

    assign ask_move_left  = held_q[0] & ~pause;
    assign ask_move_right = held_q[1] & ~pause;
    assign ask_move_up    = held_q[2] & ~pause;
    assign ask_move_down  = held_q[3] & ~pause;
    assign ask_move_jump  = jump_active_q;

endmodule

// File: tb/tb_kong_keys_ctrl.sv
// Bench for kong_keys_ctrl: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural key/frame model.
module tb_kong_keys_ctrl;

    localparam int TMO = 4;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic [8:0] keyCode;
    logic       make;
    logic       brakee;
    logic       pause;
    logic       ask_move_left, ask_move_right, ask_move_up, ask_move_down, ask_move_jump;

    int n_checks = 0;
    int n_fail   = 0;

    kong_keys_ctrl #(.HOLD_TIMEOUT(10'(TMO))) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .keyCode        (keyCode),
        .make           (make),
        .brakee         (brakee),
        .pause          (pause),
        .ask_move_left  (ask_move_left),
        .ask_move_right (ask_move_right),
        .ask_move_up    (ask_move_up),
        .ask_move_down  (ask_move_down),
        .ask_move_jump  (ask_move_jump)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: per key "is it down" and "frames since last activity while down".
    logic [8:0] codes [5];
    bit         m_held [5];
    int         m_frames [5];
    bit         m_pend;
    bit         m_act;

    task automatic model_clear();
        for (int k = 0; k < 5; k++) begin
            m_held[k]   = 0;
            m_frames[k] = 0;
        end
        m_pend = 0;
        m_act  = 0;
    endtask

    task automatic model_cycle();
        bit fresh_jump;
        fresh_jump = 0;
        for (int k = 0; k < 5; k++) begin
            if (brakee && keyCode == codes[k]) begin
                m_held[k]   = 0;
                m_frames[k] = 0;
            end else if (make && keyCode == codes[k]) begin
                if (k == 4 && !m_held[k]) fresh_jump = 1;
                m_held[k]   = 1;
                m_frames[k] = 0;
            end else if (startOfFrame && m_held[k]) begin
                m_frames[k]++;
                if (m_frames[k] == TMO) begin
                    m_held[k]   = 0;
                    m_frames[k] = 0;
                end
            end
        end
        if (startOfFrame) begin
            m_act  = m_pend && !pause;
            m_pend = fresh_jump;
        end else if (fresh_jump) begin
            m_pend = 1;
        end
    endtask

    initial begin
        codes[0] = 9'h16B; codes[1] = 9'h174; codes[2] = 9'h175;
        codes[3] = 9'h172; codes[4] = 9'h029;
        model_clear();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) model_clear();
            else model_cycle();
        end
    end

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_left",  ask_move_left,  logic'(m_held[0] && !pause));
            check("cmp_right", ask_move_right, logic'(m_held[1] && !pause));
            check("cmp_up",    ask_move_up,    logic'(m_held[2] && !pause));
            check("cmp_down",  ask_move_down,  logic'(m_held[3] && !pause));
            check("cmp_jump",  ask_move_jump,  logic'(m_act));
        end
    end

    // Present inputs for exactly one active edge; return 1 time unit after it.
    task automatic drive(input logic m, input logic b, input logic [8:0] c, input logic s);
        make = m; brakee = b; keyCode = c; startOfFrame = s;
        @(posedge clk);
        #1;
        make = 1'b0; brakee = 1'b0; startOfFrame = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 9'h000, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL bench_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        int gap;
        int sel;
        int r;
        logic m, b, s;
        logic [8:0] c;

        resetN = 1'b0; make = 1'b0; brakee = 1'b0; startOfFrame = 1'b0;
        keyCode = 9'h000; pause = 1'b0;
        @(posedge clk); #1;
        idle(2);
        check("reset_left",  ask_move_left,  1'b0);
        check("reset_right", ask_move_right, 1'b0);
        check("reset_up",    ask_move_up,    1'b0);
        check("reset_down",  ask_move_down,  1'b0);
        check("reset_jump",  ask_move_jump,  1'b0);
        resetN = 1'b1;
        idle(3);

        // Level latency
        drive(1'b1, 1'b0, 9'h174, 1'b0);
        check("right_set", ask_move_right, 1'b1);
        idle(4);
        check("right_hold", ask_move_right, 1'b1);
        drive(1'b0, 1'b1, 9'h174, 1'b0);
        check("right_clr", ask_move_right, 1'b0);
        drive(1'b1, 1'b0, 9'h1FF, 1'b0);
        check("unknown_ignored", ask_move_left | ask_move_right | ask_move_up | ask_move_down, 1'b0);
        drive(1'b1, 1'b1, 9'h16B, 1'b0);
        check("brakee_wins", ask_move_left, 1'b0);

        // Reset mid-frame with left held
        drive(1'b1, 1'b0, 9'h16B, 1'b0);
        check("left_set", ask_move_left, 1'b1);
        resetN = 1'b0;
        #1;
        check("left_async_reset", ask_move_left, 1'b0);
        idle(2);
        resetN = 1'b1;
        idle(2);
        check("left_after_reset", ask_move_left, 1'b0);
        drive(1'b0, 1'b1, 9'h16B, 1'b0);
        check("left_release", ask_move_left, 1'b0);
        drive(1'b1, 1'b0, 9'h16B, 1'b0);
        check("left_new_make", ask_move_left, 1'b1);
        drive(1'b0, 1'b1, 9'h16B, 1'b0);

        // Jump one-shot with typematic repeats over frames of 8 cycles
        drive(1'b1, 1'b0, 9'h029, 1'b0);
        check("jump_not_yet", ask_move_jump, 1'b0);
        hi = 0;
        for (int t = 0; t < 32; t++) begin
            s = (t % 8 == 0);
            m = (t == 3 || t == 9 || t == 13 || t == 18 || t == 22);
            drive(m, 1'b0, 9'h029, s);
            if (t == 0) check("jump_starts", ask_move_jump, 1'b1);
            if (ask_move_jump === 1'b1) hi++;
        end
        check_int("jump_one_frame", hi, 8);
        drive(1'b0, 1'b1, 9'h029, 1'b0);

        // Press on the frame boundary is carried to the next frame
        drive(1'b1, 1'b0, 9'h029, 1'b1);
        check("jump_edge_0", ask_move_jump, 1'b0);
        idle(6);
        drive(1'b0, 1'b0, 9'h000, 1'b1);
        check("jump_edge_1", ask_move_jump, 1'b1);
        drive(1'b0, 1'b1, 9'h029, 1'b0);
        drive(1'b0, 1'b0, 9'h000, 1'b1);
        check("jump_edge_off", ask_move_jump, 1'b0);
        drive(1'b1, 1'b0, 9'h029, 1'b0);
        drive(1'b0, 1'b1, 9'h029, 1'b0);
        drive(1'b0, 1'b0, 9'h000, 1'b1);
        check("jump_tap", ask_move_jump, 1'b1);
        drive(1'b0, 1'b0, 9'h000, 1'b1);
        check("jump_tap_off", ask_move_jump, 1'b0);

        // Stuck-key watchdog
        drive(1'b1, 1'b0, 9'h172, 1'b0);
        check("down_set", ask_move_down, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(2);
            drive(1'b0, 1'b0, 9'h000, 1'b1);
            check("down_before_tmo", ask_move_down, 1'b1);
        end
        idle(2);
        drive(1'b0, 1'b0, 9'h000, 1'b1);
        check("down_tmo", ask_move_down, 1'b0);

        // Pause
        drive(1'b1, 1'b0, 9'h175, 1'b0);
        check("up_set", ask_move_up, 1'b1);
        pause = 1'b1;
        #1;
        check("up_paused", ask_move_up, 1'b0);
        drive(1'b1, 1'b0, 9'h029, 1'b0);
        drive(1'b0, 1'b0, 9'h000, 1'b1);
        check("jump_paused", ask_move_jump, 1'b0);
        idle(1);
        pause = 1'b0;
        idle(1);
        check("up_unpaused", ask_move_up, 1'b1);
        check("jump_after_pause", ask_move_jump, 1'b0);
        drive(1'b0, 1'b0, 9'h000, 1'b1);
        check("jump_discarded", ask_move_jump, 1'b0);
        drive(1'b0, 1'b1, 9'h175, 1'b0);
        drive(1'b0, 1'b1, 9'h029, 1'b0);

        // Randomized traffic
        gap = 0;
        for (int t = 0; t < 6000; t++) begin
            s = (gap == 0);
            gap = s ? int'($urandom_range(4, 11)) : gap - 1;
            r = int'($urandom_range(0, 99));
            m = (r < 15) || (r >= 25 && r < 27);
            b = (r >= 15 && r < 27);
            sel = int'($urandom_range(0, 6));
            c = (sel < 5) ? codes[sel] : 9'($urandom);
            if ($urandom_range(0, 149) == 0) pause = ~pause;
            if ($urandom_range(0, 799) == 0) begin
                resetN = 1'b0;
                drive(m, b, c, s);
                resetN = 1'b1;
            end else begin
                drive(m, b, c, s);
            end
        end
        pause = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
